// File: rtl/mem_stage_sram_ctrl.sv
// ---------------------------------------------------------------------------
// mem_stage_sram_ctrl
//
// Memory-stage controller for a 16-bit asynchronous SRAM. Each 32-bit load or
// store from EX/MEM is split into two half-word accesses (low half, then high
// half). Each half is held for WAIT_CYCLES cycles. While an access is in
// flight, `ready` is low so the pipeline registers and the PC stay frozen.
// The load result is registered into `read_data`. The MEM/WB register
// samples it on the DONE->IDLE edge.
//
// Ports
//   clk, rst      : rising-edge clock, asynchronous active-high reset
//   wr_en, rd_en  : store / load request (both high counts as a store)
//   address       : byte address of the access (ALU result)
//   write_data    : store data
//   read_data     : registered load result, held until the next load
//   ready         : pipeline may advance when high
//   sram_addr     : SRAM half-word address
//   sram_dq_out   : data driven onto the SRAM pads during write phases
//   sram_dq_in    : data returned by the SRAM
//   sram_dq_oe    : pad output enable, high only during write phases
//   sram_we_n     : SRAM write enable, active-low
// ---------------------------------------------------------------------------
module mem_stage_sram_ctrl #(
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned WAIT_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  input  logic [15:0] sram_dq_in,
  output logic        sram_dq_oe,
  output logic        sram_we_n
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t           state;
  logic             op_wr;
  logic [31:0]      addr_q;
  logic [31:0]      data_q;
  logic [CNT_W-1:0] cnt;

  // Sequencer. DONE always returns to IDLE without looking at the request
  // inputs: the finishing instruction still holds its enable during DONE and
  // must not be serviced twice.
  // NOTE: state registers use non-blocking assignments so every register
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      op_wr     <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      cnt       <= '0;
      read_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_en || rd_en) begin
            op_wr  <= wr_en;      // store wins when both enables are high
            addr_q <= address;
            data_q <= write_data;
            cnt    <= '0;
            state  <= LOW;
          end
        end
        LOW: begin
          if (cnt == CNT_LAST) begin
            if (!op_wr) read_data[15:0] <= sram_dq_in;
            cnt   <= '0;
            state <= HIGH;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        HIGH: begin
          if (cnt == CNT_LAST) begin
            if (!op_wr) read_data[31:16] <= sram_dq_in;
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;   // DONE
      endcase
    end
  end

  // SRAM word index: offset from BASE_ADDR with modulo-2^32 wrap, then keep
  // byte-address bits [18:2]. Higher bits are discarded and no range check
  // is done.
  logic [16:0] word_idx;
  logic        half_sel;
  logic        write_phase;

  assign word_idx    = 17'((addr_q - 32'(BASE_ADDR)) >> 2);
  assign half_sel    = (state == HIGH) || (state == DONE);
  assign write_phase = op_wr && ((state == LOW) || (state == HIGH));

  // NOTE: every output gets a default first so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    sram_addr   = {word_idx, half_sel};
    sram_we_n   = 1'b1;
    sram_dq_oe  = 1'b0;
    sram_dq_out = '0;
    if (write_phase) begin
      sram_we_n   = 1'b0;
      sram_dq_oe  = 1'b1;
      sram_dq_out = (state == HIGH) ? data_q[31:16] : data_q[15:0];
    end
  end

  // The stall must be visible in the same cycle the request appears, so
  // ready looks at the enables directly.
  assign ready = ((state == IDLE) && !(rd_en || wr_en)) || (state == DONE);

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_stage_sram_ctrl
//
// Directed bench for mem_stage_sram_ctrl (BASE_ADDR=1024, WAIT_CYCLES=3).
// A small behavioural SRAM, 64 half-words indexed by sram_addr[5:0], answers
// loads and absorbs stores. Outputs are sampled on the falling edge. Inputs
// change 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_mem_stage_sram_ctrl;

  localparam int W = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, rd_en;
  logic [31:0] address, write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [15:0] mem [0:63];

  mem_stage_sram_ctrl #(.BASE_ADDR(1024), .WAIT_CYCLES(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .sram_addr  (sram_addr),
    .sram_dq_out(sram_dq_out),
    .sram_dq_in (sram_dq_in),
    .sram_dq_oe (sram_dq_oe),
    .sram_we_n  (sram_we_n)
  );

  always #5 clk = ~clk;

  assign sram_dq_in = mem[sram_addr[5:0]];
  always @(posedge clk) if (!sram_we_n) mem[sram_addr[5:0]] <= sram_dq_out;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // One full access starting from IDLE. Checks every cycle from the request
  // cycle through DONE. With hold=0 the request is withdrawn (and address/data
  // scrambled) after cycle 0. With hold=1 it stays asserted through DONE.
  task automatic access(input string name, input logic w, input logic r,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [17:0] lo_addr, input logic [31:0] exp_rd,
                        input bit hold);
    logic        half;
    logic [15:0] exp_dq;
    @(posedge clk); #1;
    wr_en = w; rd_en = r; address = a; write_data = d;
    @(negedge clk);
    check({name, " c0 ready"}, 32'(ready), 32'd0);
    for (int c = 1; c <= 2*W; c++) begin
      @(posedge clk); #1;
      if (!hold && c == 1) begin
        wr_en = 1'b0; rd_en = 1'b0; address = ~a; write_data = ~d;
      end
      @(negedge clk);
      half   = (c > W);
      exp_dq = w ? (half ? d[31:16] : d[15:0]) : 16'h0;
      check($sformatf("%s c%0d addr", name, c),  32'(sram_addr), 32'({lo_addr[17:1], half}));
      check($sformatf("%s c%0d we_n", name, c),  32'(sram_we_n), 32'(!w));
      check($sformatf("%s c%0d oe", name, c),    32'(sram_dq_oe), 32'(w));
      check($sformatf("%s c%0d dq", name, c),    32'(sram_dq_out), 32'(exp_dq));
      check($sformatf("%s c%0d ready", name, c), 32'(ready), 32'd0);
    end
    @(posedge clk); #1;
    @(negedge clk);
    check({name, " done ready"}, 32'(ready), 32'd1);
    check({name, " done we_n"},  32'(sram_we_n), 32'd1);
    check({name, " done oe"},    32'(sram_dq_oe), 32'd0);
    check({name, " done addr"},  32'(sram_addr), 32'({lo_addr[17:1], 1'b1}));
    check({name, " done rdata"}, read_data, exp_rd);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'h0;
    mem[4]  = 16'hBEEF; mem[5]  = 16'hDEAD;
    mem[6]  = 16'h1234; mem[7]  = 16'h5678;
    mem[62] = 16'hAAAA; mem[63] = 16'h5555;

    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
    #3;
    // Reset state: addr_q=0 gives word 0xFFFFFC00, so sram_addr = 0x3FE00.
    check("rst ready", 32'(ready), 32'd1);
    check("rst rdata", read_data, 32'd0);
    check("rst we_n",  32'(sram_we_n), 32'd1);
    check("rst oe",    32'(sram_dq_oe), 32'd0);
    check("rst dq",    32'(sram_dq_out), 32'd0);
    check("rst addr",  32'(sram_addr), 32'h3FE00);
    #4 rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("idle%0d ready", i), 32'(ready), 32'd1);
      check($sformatf("idle%0d we_n", i),  32'(sram_we_n), 32'd1);
    end

    // Store, then load back the same word (1032 -> half-words 4/5).
    access("st1032", 1'b1, 1'b0, 32'd1032, 32'hDEADBEEF, 18'd4, 32'h0, 1'b0);
    access("ld1032", 1'b0, 1'b1, 32'd1032, 32'h0,        18'd4, 32'hDEADBEEF, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("hold%0d rdata", i), read_data, 32'hDEADBEEF);
      check($sformatf("hold%0d ready", i), 32'(ready), 32'd1);
    end

    // Back-to-back with the request held: the load of 1036 (half-words 6/7)
    // is followed directly by a store to 1040 (half-words 8/9).
    access("b2b_ld", 1'b0, 1'b1, 32'd1036, 32'h0,        18'd6, 32'h56781234, 1'b1);
    access("b2b_st", 1'b1, 1'b0, 32'd1040, 32'hCAFEF00D, 18'd8, 32'h56781234, 1'b1);
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
    @(negedge clk);
    check("b2b idle ready", 32'(ready), 32'd1);
    check("b2b mem8",       32'(mem[8]), 32'h0000F00D);
    check("b2b mem9",       32'(mem[9]), 32'h0000CAFE);

    // Both enables high: the access is a store and read_data is unchanged.
    access("both", 1'b1, 1'b1, 32'd1044, 32'h0BADF00D, 18'd10, 32'h56781234, 1'b0);
    check("both mem10", 32'(mem[10]), 32'h0000F00D);

    // Address below BASE_ADDR wraps: 1020 -> word idx 0x1FFFF -> 0x3FFFE/F.
    access("wrap", 1'b0, 1'b1, 32'd1020, 32'h0, 18'h3FFFE, 32'h5555AAAA, 1'b0);

    // Reset during the HIGH phase of a load.
    @(posedge clk); #1;
    rd_en = 1'b1; address = 32'd1032;
    @(posedge clk); #1;
    rd_en = 1'b0; address = 32'h0;
    repeat (W + 1) @(posedge clk);
    #1;
    check("abort pre rdlo", 32'(read_data[15:0]), 32'h0000BEEF);
    check("abort pre addr", 32'(sram_addr), 32'd5);
    rst = 1'b1;
    #1;
    check("abort ready", 32'(ready), 32'd1);
    check("abort rdata", read_data, 32'd0);
    check("abort we_n",  32'(sram_we_n), 32'd1);
    check("abort addr",  32'(sram_addr), 32'h3FE00);
    #1 rst = 1'b0;

    access("ld_after", 1'b0, 1'b1, 32'd1032, 32'h0, 18'd4, 32'hDEADBEEF, 1'b0);
    @(negedge clk);
    check("final idle ready", 32'(ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage_sram_ctrl.md
# mem_stage_sram_ctrl

Memory-stage controller that services the pipeline's data-memory accesses against an external 16-bit asynchronous SRAM. It splits each 32-bit load/store into two 16-bit half-word accesses and holds each half for a fixed number of wait cycles. It drops `ready` to freeze the pipeline for the duration. It sits between the EX/MEM pipeline register (request side) and the MEM/WB pipeline register, which consumes `read_data` and is enabled by `ready`.

## Interface
- `BASE_ADDR`, 1024: byte address mapped to SRAM word 0.
- `WAIT_CYCLES`, 3: cycles each half-word access is held. Must be ≥1.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `wr_en` in 1: store request from EX/MEM.
- `rd_en` in 1: load request from EX/MEM.
- `address` in 32: byte address (ALU result).
- `write_data` in 32: store data.
- `read_data` out 32: registered load result.
- `ready` out 1: high means the pipeline may advance; low freezes all pipeline registers and the PC.
- `sram_addr` out 18: SRAM half-word address.
- `sram_dq_out` out 16: data driven to SRAM on writes.
- `sram_dq_in` in 16: data returned from SRAM.
- `sram_dq_oe` out 1: pad output enable; 1 during write phases only.
- `sram_we_n` out 1: SRAM write enable, active-low.

## Operation
- Operation registers: `op_wr`, `addr_q[31:0]`, `data_q[31:0]`.
- Counter: `cnt`, sized ⌈log2(WAIT_CYCLES)⌉ bits, minimum 1 bit.
- FSM states: IDLE, LOW, HIGH, DONE.
- IDLE:
  - If `wr_en|rd_en`, latch `op_wr=wr_en`, `addr_q=address`, `data_q=write_data`, clear `cnt`, and go to LOW.
  - If both enables are high, the request is treated as a write.
  - With no request, stay in IDLE.
- LOW:
  - Access the low half-word; `cnt` increments each cycle.
  - When `cnt==WAIT_CYCLES-1`: on a read, capture `read_data[15:0]<=sram_dq_in`. Then clear `cnt` and go to HIGH.
- HIGH:
  - Same as LOW for the high half. On exit, a read captures `read_data[31:16]`. Go to DONE.
- DONE: one cycle, then go unconditionally to IDLE. The still-asserted request of the finishing instruction must not restart an access.
- Address mapping:
  - `word = (addr_q - BASE_ADDR)`, computed as 32-bit unsigned with modulo wrap.
  - `sram_addr = {word[18:2], half}`, where half is 0 in LOW and 1 in HIGH.
  - No range check is performed; bits above bit 18 are discarded.
- In LOW/HIGH with `op_wr`:
  - `sram_we_n=0` and `sram_dq_oe=1`.
  - `sram_dq_out` is `data_q[15:0]` in LOW and `data_q[31:16]` in HIGH.
- In every other case:
  - `sram_we_n=1`, `sram_dq_oe=0`, `sram_dq_out=0`.
  - `sram_addr` is `{word[18:2],1'b0}` in IDLE and `{word[18:2],1'b1}` in DONE.
- `ready` is combinational: `(state==IDLE && !(rd_en||wr_en)) || state==DONE`.
- `read_data` holds its value until the next read captures. Writes never modify it.

## Timing
- Reset (asynchronous, any state):
  - State goes to IDLE; `cnt`, `op_wr`, `addr_q`, `data_q` and `read_data` go to 0.
  - `sram_we_n=1`, `sram_dq_oe=0`, `sram_dq_out=0`, `sram_addr=word[18:2]` of `addr_q=0`.
  - `ready` reflects the IDLE equation immediately.
  - A reset during LOW/HIGH aborts the access; a partially captured `read_data` is cleared.
- Request first visible in IDLE (cycle 0): `ready=0` in that same cycle.
- Phase durations: LOW covers cycles 1..W, HIGH covers cycles W+1..2W, DONE is cycle 2W+1.
- `ready` is low for 2W+1 consecutive cycles, then high for exactly one cycle (DONE). W=3 gives 7 low cycles and `ready` high in cycle 7.
- `read_data` is complete and stable throughout DONE. MEM/WB samples it at the DONE→IDLE edge.
- Back-to-back requests: the next instruction's request is seen in IDLE in cycle 2W+2 and the sequence repeats. There is no idle gap beyond the single IDLE cycle.
- Address and data are stable for all W cycles of each phase; the `sram_we_n` low pulse is W cycles per half.
- Input changes after cycle 0 do not affect an access in progress.

## Test plan
- Reset while idle → `ready=1`, `read_data=0`, `sram_we_n=1`, `sram_dq_oe=0`; then hold `rd_en=wr_en=0` for 10 cycles → `ready` stays 1 and `sram_we_n` stays 1.
- Store: `wr_en=1`, `address=1032`, `write_data=32'hDEADBEEF`, W=3. Required response:
  - `sram_addr=4`, `sram_dq_out=16'hBEEF`, `we_n=0` for 3 cycles.
  - Then `sram_addr=5`, `sram_dq_out=16'hDEAD`, `we_n=0` for 3 cycles.
  - `ready=0` for 7 cycles, then 1 for one cycle.
- Load: `rd_en=1`, `address=1032`; SRAM model returns 16'hBEEF at half-address 4 and 16'hDEAD at half-address 5 → `read_data=32'hDEADBEEF` in DONE and held afterwards.
- Back-to-back load then store with the request held continuously → no restart in DONE; the second access begins exactly one cycle after DONE.
- Simultaneous `rd_en=wr_en=1` → the access is a write and `read_data` is unchanged.
- Assert `rst` during HIGH of a read → IDLE at once, `read_data=0`, `we_n=1`; a subsequent read completes normally in 2W+2 cycles.
